// File: rtl/control_sequencer_if.sv
// Decoded-field inputs and control outputs of the 4-bit CPU sequencer.
// master: the sequencer side. slave: the datapath/IR side.
interface control_sequencer_if #(
    parameter int unsigned IMM_W = 4
);
    logic [3:0]       op_code;
    logic [1:0]       reg_sel;
    logic [1:0]       data;
    logic             zero_flag;
    logic             ir_load_en;
    logic             pc_inc;
    logic             pc_load;
    logic [IMM_W-1:0] pc_target;
    logic [1:0]       reg_rsel_a;
    logic [1:0]       reg_rsel_b;
    logic             reg_we;
    logic [1:0]       reg_wsel;
    logic [2:0]       alu_op;
    logic             alu_b_imm;
    logic [IMM_W-1:0] imm;
    logic             halted;
    logic             illegal;

    modport master (
        input  op_code, reg_sel, data, zero_flag,
        output ir_load_en, pc_inc, pc_load, pc_target, reg_rsel_a, reg_rsel_b,
               reg_we, reg_wsel, alu_op, alu_b_imm, imm, halted, illegal
    );

    modport slave (
        output op_code, reg_sel, data, zero_flag,
        input  ir_load_en, pc_inc, pc_load, pc_target, reg_rsel_a, reg_rsel_b,
               reg_we, reg_wsel, alu_op, alu_b_imm, imm, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Three-cycle fetch/decode/execute sequencer; HLT is terminal until reset.
// Optional macro CTRL_ILLEGAL_TRAP_EN: opcodes 1100-1110 set sticky illegal and halt.
module control_sequencer #(
    parameter int unsigned IMM_W = 4
) (
    input logic               clk,
    input logic               reset,
    control_sequencer_if.master bus
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDecode  = 3'd2;
    localparam logic [2:0] StExecute = 3'd3;
    localparam logic [2:0] StHalt    = 3'd4;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluXor   = 3'b100;
    localparam logic [2:0] AluNot   = 3'b101;
    localparam logic [2:0] AluPassb = 3'b110;

    logic [2:0] state_q, state_d;
    logic       is_hlt;
    logic       trap;

    assign is_hlt = (bus.op_code == 4'b1111);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic is_illegal;
    logic illegal_q;

    assign is_illegal = (bus.op_code[3:2] == 2'b11) && !is_hlt;
    assign trap       = is_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if (state_q == StExecute && is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign trap        = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:    state_d = StFetch;
            StFetch:   state_d = StDecode;
            StDecode:  state_d = StExecute;
            StExecute: state_d = (is_hlt || trap) ? StHalt : StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StIdle;
        endcase
    end

    assign bus.halted = (state_q == StHalt);

    always_comb begin
        bus.ir_load_en = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_target  = '0;
        bus.reg_rsel_a = 2'b00;
        bus.reg_rsel_b = 2'b00;
        bus.reg_we     = 1'b0;
        bus.reg_wsel   = 2'b00;
        bus.alu_op     = AluAdd;
        bus.alu_b_imm  = 1'b0;
        bus.imm        = '0;

        case (state_q)
            StFetch: begin
                bus.ir_load_en = 1'b1;
                bus.pc_inc     = 1'b1;
            end
            StDecode: begin
                bus.reg_rsel_a = bus.reg_sel;
                bus.reg_rsel_b = bus.data;
            end
            StExecute: begin
                bus.reg_rsel_a = bus.reg_sel;
                bus.reg_rsel_b = bus.data;
                case (bus.op_code)
                    4'b0001: begin
                        bus.reg_we    = 1'b1;
                        bus.alu_op    = AluPassb;
                        bus.alu_b_imm = 1'b1;
                        bus.imm       = IMM_W'(bus.data);
                    end
                    4'b0010: begin bus.reg_we = 1'b1; bus.alu_op = AluAdd; end
                    4'b0011: begin bus.reg_we = 1'b1; bus.alu_op = AluSub; end
                    4'b0100: begin bus.reg_we = 1'b1; bus.alu_op = AluAnd; end
                    4'b0101: begin bus.reg_we = 1'b1; bus.alu_op = AluOr;  end
                    4'b0110: begin bus.reg_we = 1'b1; bus.alu_op = AluXor; end
                    4'b0111: begin bus.reg_we = 1'b1; bus.alu_op = AluNot; end
                    4'b1000, 4'b1001: begin
                        bus.reg_we    = 1'b1;
                        bus.alu_op    = bus.op_code[0] ? AluSub : AluAdd;
                        bus.alu_b_imm = 1'b1;
                        bus.imm       = IMM_W'(1);
                    end
                    4'b1010: begin
                        bus.pc_load   = 1'b1;
                        bus.pc_target = IMM_W'({bus.reg_sel, bus.data});
                    end
                    4'b1011: begin
                        bus.pc_load   = bus.zero_flag;
                        bus.pc_target = IMM_W'({bus.reg_sel, bus.data});
                    end
                    // NOP, HLT and the illegal range assert nothing here
                    default: ;
                endcase
                if (bus.reg_we) begin
                    bus.reg_wsel = bus.reg_sel;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each stimulus cycle queues its expected
// output vector; a monitor on the falling edge pops and compares.
module tb_control_sequencer;
    typedef struct packed {
        logic       ir;
        logic       inc;
        logic       pcl;
        logic [3:0] tgt;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       we;
        logic [1:0] ws;
        logic [2:0] aop;
        logic       bimm;
        logic [3:0] imm;
        logic       halt;
        logic       ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        string nm;
    } item_t;

    logic  clk;
    logic  reset;
    int    checks;
    int    failures;
    item_t sb_q[$];

    control_sequencer_if #(.IMM_W(4)) bus ();

    control_sequencer #(.IMM_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic pcl, input logic [3:0] tgt, input logic [1:0] ra,
                                input logic [1:0] rb, input logic we, input logic [1:0] ws,
                                input logic [2:0] aop, input logic bimm, input logic [3:0] imm);
        exp_t e;
        e      = '0;
        e.pcl  = pcl;
        e.tgt  = tgt;
        e.ra   = ra;
        e.rb   = rb;
        e.we   = we;
        e.ws   = ws;
        e.aop  = aop;
        e.bimm = bimm;
        e.imm  = imm;
        return e;
    endfunction

    function automatic exp_t dec(input logic [1:0] ra, input logic [1:0] rb);
        return ex(1'b0, 4'h0, ra, rb, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0);
    endfunction

    function automatic exp_t fetch_e();
        exp_t e;
        e     = '0;
        e.ir  = 1'b1;
        e.inc = 1'b1;
        return e;
    endfunction

    function automatic exp_t halt_e(input logic ill);
        exp_t e;
        e      = '0;
        e.halt = 1'b1;
        e.ill  = ill;
        return e;
    endfunction

    // One clock: apply inputs just after the rising edge and queue what that cycle must show
    task automatic cyc(input logic rst, input logic [3:0] op, input logic [1:0] rs,
                       input logic [1:0] d, input logic z, input exp_t e, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.op_code   = op;
        bus.reg_sel   = rs;
        bus.data      = d;
        bus.zero_flag = z;
        it.e  = e;
        it.nm = nm;
        sb_q.push_back(it);
    endtask

    task automatic inst(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] d,
                        input logic z, input exp_t exe, input string nm);
        cyc(1'b1, op, rs, d, z, fetch_e(), {nm, "_fetch"});
        cyc(1'b1, op, rs, d, z, dec(rs, d), {nm, "_decode"});
        cyc(1'b1, op, rs, d, z, exe, {nm, "_exec"});
    endtask

    always @(negedge clk) begin
        item_t it;
        exp_t  act;
        if (sb_q.size() > 0) begin
            it       = sb_q.pop_front();
            act.ir   = bus.ir_load_en;
            act.inc  = bus.pc_inc;
            act.pcl  = bus.pc_load;
            act.tgt  = bus.pc_target;
            act.ra   = bus.reg_rsel_a;
            act.rb   = bus.reg_rsel_b;
            act.we   = bus.reg_we;
            act.ws   = bus.reg_wsel;
            act.aop  = bus.alu_op;
            act.bimm = bus.alu_b_imm;
            act.imm  = bus.imm;
            act.halt = bus.halted;
            act.ill  = bus.illegal;
            checks++;
            if (act !== it.e) begin
                failures++;
                $display("FAIL %s: got %b required %b (ir inc pcl tgt ra rb we ws aop bimm imm halt ill)",
                         it.nm, act, it.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.op_code   = 4'h0;
        bus.reg_sel   = 2'b00;
        bus.data      = 2'b00;
        bus.zero_flag = 1'b0;

        cyc(1'b0, 4'h0, 2'b00, 2'b00, 1'b0, '0, "reset_0");
        cyc(1'b0, 4'h0, 2'b00, 2'b00, 1'b0, '0, "reset_1");
        cyc(1'b1, 4'h0, 2'b00, 2'b00, 1'b0, '0, "idle_after_reset");

        inst(4'b0010, 2'b01, 2'b10, 1'b0,
             ex(1'b0, 4'h0, 2'b01, 2'b10, 1'b1, 2'b01, 3'b000, 1'b0, 4'h0), "add");
        inst(4'b0001, 2'b11, 2'b01, 1'b0,
             ex(1'b0, 4'h0, 2'b11, 2'b01, 1'b1, 2'b11, 3'b110, 1'b1, 4'h1), "ldi");
        inst(4'b1011, 2'b10, 2'b11, 1'b1,
             ex(1'b1, 4'hb, 2'b10, 2'b11, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0), "jz_taken");
        inst(4'b1011, 2'b10, 2'b11, 1'b0,
             ex(1'b0, 4'hb, 2'b10, 2'b11, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0), "jz_not_taken");
        inst(4'b0011, 2'b00, 2'b01, 1'b0,
             ex(1'b0, 4'h0, 2'b00, 2'b01, 1'b1, 2'b00, 3'b001, 1'b0, 4'h0), "sub");
        inst(4'b0100, 2'b00, 2'b11, 1'b0,
             ex(1'b0, 4'h0, 2'b00, 2'b11, 1'b1, 2'b00, 3'b010, 1'b0, 4'h0), "and");
        inst(4'b0101, 2'b01, 2'b01, 1'b0,
             ex(1'b0, 4'h0, 2'b01, 2'b01, 1'b1, 2'b01, 3'b011, 1'b0, 4'h0), "or");
        inst(4'b0110, 2'b11, 2'b10, 1'b0,
             ex(1'b0, 4'h0, 2'b11, 2'b10, 1'b1, 2'b11, 3'b100, 1'b0, 4'h0), "xor");
        inst(4'b0111, 2'b01, 2'b00, 1'b0,
             ex(1'b0, 4'h0, 2'b01, 2'b00, 1'b1, 2'b01, 3'b101, 1'b0, 4'h0), "not");
        inst(4'b1000, 2'b10, 2'b00, 1'b0,
             ex(1'b0, 4'h0, 2'b10, 2'b00, 1'b1, 2'b10, 3'b000, 1'b1, 4'h1), "inc");
        inst(4'b0000, 2'b11, 2'b11, 1'b1,
             ex(1'b0, 4'h0, 2'b11, 2'b11, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0), "nop");

        inst(4'b1101, 2'b01, 2'b10, 1'b0,
             ex(1'b0, 4'h0, 2'b01, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0), "illegal");
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(1'b1, 4'b1101, 2'b01, 2'b10, 1'b0, halt_e(1'b1), "illegal_trap_0");
        cyc(1'b1, 4'b1101, 2'b01, 2'b10, 1'b0, halt_e(1'b1), "illegal_trap_1");
        cyc(1'b0, 4'b1101, 2'b01, 2'b10, 1'b0, '0, "illegal_reset");
        cyc(1'b1, 4'b0000, 2'b00, 2'b00, 1'b0, '0, "illegal_idle");
`endif
        inst(4'b1001, 2'b11, 2'b00, 1'b0,
             ex(1'b0, 4'h0, 2'b11, 2'b00, 1'b1, 2'b11, 3'b001, 1'b1, 4'h1), "dec");

        // Reset landing in EXECUTE must kill the write strobe at once
        cyc(1'b1, 4'b0010, 2'b10, 2'b01, 1'b0, fetch_e(), "midreset_fetch");
        cyc(1'b1, 4'b0010, 2'b10, 2'b01, 1'b0, dec(2'b10, 2'b01), "midreset_decode");
        cyc(1'b0, 4'b0010, 2'b10, 2'b01, 1'b0, '0, "midreset_exec");
        cyc(1'b1, 4'b0010, 2'b10, 2'b01, 1'b0, '0, "midreset_idle");

        inst(4'b1010, 2'b01, 2'b10, 1'b0,
             ex(1'b1, 4'h6, 2'b01, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 4'h0), "jmp");
        inst(4'b1111, 2'b00, 2'b00, 1'b0, '0, "hlt");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'b0010, 2'b01, 2'b10, 1'b1, halt_e(1'b0), "halted");
        end
        cyc(1'b0, 4'b0000, 2'b00, 2'b00, 1'b0, '0, "halt_reset");
        cyc(1'b1, 4'b0000, 2'b00, 2'b00, 1'b0, '0, "halt_idle");
        inst(4'b0010, 2'b10, 2'b11, 1'b0,
             ex(1'b0, 4'h0, 2'b10, 2'b11, 1'b1, 2'b10, 3'b000, 1'b0, 4'h0), "add_after_halt");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
